// File: rtl/bus_gate_arbiter.sv
// Round-robin gate arbiter for the shared 16-bit datapath bus.
// Registered one-hot select with one dead turnaround cycle between owners.
module bus_gate_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] req,
  output logic [3:0] gate,
  output logic       busy,
  output logic [1:0] owner
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] LIM = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n;
  logic [1:0]      own_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      gate_n;
  logic [1:0]      win, idx;
  logic            found;
  logic            own_req;
  logic            others;

  // requester i drives select bit 3-i
  function automatic logic [3:0] sel(input logic [1:0] i);
    return 4'b1000 >> i;
  endfunction

  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[2'd3 - idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign own_req = req[2'd3 - owner];
  assign others  = |(req & ~sel(owner));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      owner <= 2'd0;
      gate  <= 4'b0000;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      owner <= own_n;
      gate  <= gate_n;
      busy  <= |gate_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    own_n   = owner;
    cnt_n   = cnt;
    unique case (state)
      IDLE, TURN: begin
        if (found) begin
          own_n   = win;
          ptr_n   = win + 2'd1;
          cnt_n   = '0;
          state_n = OWN;
        end else begin
          state_n = IDLE;
        end
      end
      OWN: begin
        // a drop and the hold limit together still give a single TURN
        if (!own_req || (cnt == LIM && others)) begin
          state_n = TURN;
        end else if (cnt != LIM) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gate_n = 4'b0000;
    if (state_n == OWN) begin
      gate_n = sel(own_n);
    end
  end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench for bus_gate_arbiter.
// Runs a HOLD_MAX=8 instance and a HOLD_MAX=1 instance.
module tb_bus_gate_arbiter;

  logic       Clk;
  logic       Reset;
  logic [3:0] req8, req1;
  logic [3:0] gate8, gate1;
  logic       busy8, busy1;
  logic [1:0] owner8, owner1;

  int errs;
  int nchk;

  bus_gate_arbiter #(.HOLD_MAX(8)) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .req   (req8),
    .gate  (gate8),
    .busy  (busy8),
    .owner (owner8)
  );

  bus_gate_arbiter #(.HOLD_MAX(1)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .req   (req1),
    .gate  (gate1),
    .busy  (busy1),
    .owner (owner1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  logic [3:0] eg;
  logic [1:0] eo;

  initial begin
    errs  = 0;
    nchk  = 0;
    Reset = 1'b0;
    req8  = 4'b0000;
    req1  = 4'b0000;
    #1;
    chk("rst_gate", 8'(gate8), 8'h00);
    chk("rst_busy", 8'(busy8), 8'h00);
    chk("rst_owner", 8'(owner8), 8'h00);
    tick();
    Reset = 1'b1;
    tick();
    chk("idle_gate", 8'(gate8), 8'h00);

    // single requester 2 for three edges
    for (int i = 0; i < 3; i++) begin
      req8 = 4'b0010;
      tick();
      chk("single_gate", 8'(gate8), 8'b0010);
      chk("single_busy", 8'(busy8), 8'h01);
    end
    req8 = 4'b0000;
    tick();
    chk("single_turn", 8'(gate8), 8'h00);
    chk("single_turn_busy", 8'(busy8), 8'h00);
    chk("single_owner", 8'(owner8), 8'd2);
    tick();
    chk("single_idle", 8'(gate8), 8'h00);

    // ptr now sits at 3
    req8 = 4'b1111;
    tick();
    chk("ptr3_gate", 8'(gate8), 8'b0001);
    chk("ptr3_owner", 8'(owner8), 8'd3);

    // async reset mid-OWN
    #1 Reset = 1'b0;
    #1;
    chk("arst_gate", 8'(gate8), 8'h00);
    chk("arst_busy", 8'(busy8), 8'h00);
    chk("arst_owner", 8'(owner8), 8'h00);
    tick();
    Reset = 1'b1;

    // full contention, HOLD_MAX=8
    for (int r = 0; r < 5; r++) begin
      eg = 4'b1000 >> r[1:0];
      eo = r[1:0];
      for (int j = 0; j < 8; j++) begin
        tick();
        chk("cont_gate", 8'(gate8), 8'(eg));
        chk("cont_owner", 8'(owner8), 8'(eo));
      end
      if (r < 4) begin
        tick();
        chk("cont_turn", 8'(gate8), 8'h00);
      end
    end

    // owner 0 drops, requester 3 alone
    req8 = 4'b0001;
    tick();
    chk("lone_turn", 8'(gate8), 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lone_gate", 8'(gate8), 8'b0001);
    end
    chk("lone_owner", 8'(owner8), 8'd3);

    // fairness: owner 0 drops with 1 and 3 pending
    req8 = 4'b1000;
    tick();
    chk("fair_turn0", 8'(gate8), 8'h00);
    tick();
    chk("fair_own0", 8'(gate8), 8'b1000);
    req8 = 4'b0101;
    tick();
    chk("fair_turn1", 8'(gate8), 8'h00);
    req8 = 4'b1101;
    tick();
    chk("fair_gate", 8'(gate8), 8'b0100);
    chk("fair_owner", 8'(owner8), 8'd1);

    // HOLD_MAX=1 alternation
    req1 = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (i % 4)
        0: eg = 4'b1000;
        2: eg = 4'b0001;
        default: eg = 4'b0000;
      endcase
      chk("h1_gate", 8'(gate1), 8'(eg));
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/bus_gate_arbiter.md
# bus_gate_arbiter

- Round-robin arbiter that shares the 16-bit internal datapath bus among four bus drivers.
- Generates the registered one-hot gate select that feeds the bus multiplexer's 4-bit select. Select bit 3 enables input d0 and bit 0 enables d3; all-zero means no driver.
- Guarantees at most one driver per cycle, a bounded ownership time under contention, and one dead turnaround cycle between owners.

## Interface
Parameters:
- HOLD_MAX, 8, maximum consecutive cycles an owner keeps the bus while another requester is pending; legal range ≥1.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  4  bus requests, level-sensitive. req[3] is requester 0 (d0); req[0] is requester 3 (d3).
- gate  out  4  registered one-hot or all-zero bus select, bit order identical to req.
- busy  out  1  registered; 1 when gate is non-zero.
- owner  out  2  registered index (0..3) of the most recent winner.

## Operation
- States: IDLE, OWN, TURN.
- Internal registers:
  - ptr[1:0]: round-robin pointer; the requester with highest priority next.
  - cnt: hold counter, width max(1, $clog2(HOLD_MAX)).
- Arbitration (evaluated in IDLE and TURN):
  - Search requesters ptr, ptr+1, … mod 4; the first with an asserted req wins.
  - On a win: owner ← winner, ptr ← winner+1 mod 4, cnt ← 0, next state OWN.
  - With no request: next state IDLE.
- IDLE: gate=0000, busy=0.
- OWN: gate has only the owner's bit set, busy=1. Each cycle:
  - Release to TURN when req of the owner is 0.
  - Release to TURN when cnt==HOLD_MAX-1 and any other req bit is 1.
  - Otherwise stay in OWN and increment cnt, saturating at HOLD_MAX-1. A lone owner keeps the bus indefinitely.
- TURN: gate=0000, busy=0 for exactly one cycle. Arbitrates as above; a new owner's gate appears on the following edge.
- The releasing owner may re-request during TURN. It competes at the lowest priority because ptr has already advanced past it.
- gate is never multi-hot in any state or after any reset sequence.
- Outputs change only at the rising edge of Clk, except during asynchronous reset.

## Timing
- Reset asserted (Reset=0), immediately and without a clock edge:
  - gate=0000, busy=0, owner=0.
  - state=IDLE, ptr=0, cnt=0.
- Reset release: first arbitration at the first rising edge with Reset=1. Requester 0 has top priority.
- Grant latency:
  - A req sampled high at edge k in IDLE produces the corresponding gate bit after edge k (1 cycle).
- Release:
  - Owner req sampled low at edge k → gate=0000 after edge k.
  - A pending request then gets its gate after edge k+1.
  - The minimum gap between owners is exactly one cycle.
- Hold limit: an owner granted at edge k keeps gate through the cycle ending at edge k+HOLD_MAX. This gives at most HOLD_MAX driving cycles when contended.
- HOLD_MAX=1: each contended grant lasts one cycle, followed by one TURN cycle.
- Simultaneous events:
  - Owner drop and cnt limit occurring in the same cycle → one TURN. No double release.
  - A req change in the same cycle as a grant edge uses the value sampled at that edge.
- Reset asserted mid-OWN: gate drops to 0000 asynchronously. Bus-cycle progress is discarded and ptr returns to 0.

## Test plan
- Reset: drive req=1111 and Reset=0 mid-grant → gate=0000, busy=0, owner=0 before the next edge. Release Reset → gate=1000 one edge later.
- Single requester: req=0010 for 3 cycles, then 0000 → gate=0010 for 3 cycles starting 1 cycle after req, then one 0000 TURN cycle, then IDLE (gate=0000, busy=0).
- Full contention, HOLD_MAX=8, req=1111 held → gate sequence:
  - 1000 ×8, 0000, 0100 ×8, 0000, 0010 ×8, 0000, 0001 ×8, 0000, 1000 ×8.
  - owner steps 0,1,2,3,0.
- Lone owner saturation: req=0001 held 20 cycles → gate=0001 for all 20 cycles with no TURN. cnt saturates at 7.
- Pointer fairness: owner 0 drops req while req=0101 (requesters 1 and 3) → TURN, then gate=0100, owner=1. Requester 0 re-asserting during TURN does not win.
- HOLD_MAX=1, req=1001 held → gate alternates 1000, 0000, 0001, 0000, 1000, …; never multi-hot.
